// File: rtl/systolic_psum_collector_if.sv
// Stream bundle between the systolic array bottom row, the collector and the row consumer.
// The collector sits on the slave side; the array controller and consumer drive the master side.
interface systolic_psum_collector_if #(
  parameter int ARRAY_SIZE  = 16,
  parameter int ACCUM_WIDTH = 32,
  parameter int FIFO_DEPTH  = 32
);
  logic [ARRAY_SIZE*ACCUM_WIDTH-1:0] psum_in;
  logic                              psum_in_valid;
  logic                              stall_req;
  logic [ARRAY_SIZE*ACCUM_WIDTH-1:0] out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [$clog2(FIFO_DEPTH):0]       fifo_count;
  logic                              overflow;

  modport slave (
    input  psum_in, psum_in_valid, out_ready,
    output stall_req, out_data, out_valid, fifo_count, overflow
  );

  modport master (
    output psum_in, psum_in_valid, out_ready,
    input  stall_req, out_data, out_valid, fifo_count, overflow
  );
endinterface

// File: rtl/systolic_psum_collector.sv
// De-skews the bottom-row partial-sum wavefront into aligned rows and buffers them in a
// first-word-fall-through FIFO, stalling the array controller before the buffer can overflow.
module systolic_psum_collector #(
  parameter int ARRAY_SIZE  = 16,
  parameter int ACCUM_WIDTH = 32,
  parameter int FIFO_DEPTH  = 32
) (
  input logic clk,
  input logic rst,
  systolic_psum_collector_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = ARRAY_SIZE * ACCUM_WIDTH;

  logic [ARRAY_SIZE-2:0] vtag;
  logic [RW-1:0]         aligned;
  logic [RW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow_q;
  logic                  wr_strobe;
  logic                  full;
  logic                  pop;
  logic                  do_write;
  logic [CW:0]           space;

  // vtag[i] is psum_in_valid delayed i+1 cycles; the last tap marks a fully aligned row
  always_ff @(posedge clk) begin
    if (rst) begin
      vtag <= '0;
    end else begin
      vtag[0] <= bus.psum_in_valid;
      for (int i = 1; i < ARRAY_SIZE - 1; i++) begin
        vtag[i] <= vtag[i-1];
      end
    end
  end

  assign wr_strobe = vtag[ARRAY_SIZE-2];

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
    localparam int DLY = ARRAY_SIZE - 1 - j;
    if (DLY == 0) begin : g_direct
      assign aligned[j*ACCUM_WIDTH +: ACCUM_WIDTH] = bus.psum_in[j*ACCUM_WIDTH +: ACCUM_WIDTH];
    end else begin : g_delay
      logic [ACCUM_WIDTH-1:0] dline [DLY];
      always_ff @(posedge clk) begin
        dline[0] <= bus.psum_in[j*ACCUM_WIDTH +: ACCUM_WIDTH];
        for (int k = 1; k < DLY; k++) begin
          dline[k] <= dline[k-1];
        end
      end
      assign aligned[j*ACCUM_WIDTH +: ACCUM_WIDTH] = dline[DLY-1];
    end
  end

  assign full          = (count == CW'(FIFO_DEPTH));
  assign bus.out_valid = (count != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  // A full buffer still accepts a row when the head leaves in the same cycle
  assign do_write      = wr_strobe && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_strobe && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Headroom of ARRAY_SIZE covers the rows still travelling through the delay lines
  assign space          = (CW+1)'(FIFO_DEPTH) - {1'b0, count};
  assign bus.stall_req  = (space <= (CW+1)'(ARRAY_SIZE));
  assign bus.out_data   = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_systolic_psum_collector.sv
// Self-checking bench for systolic_psum_collector: skewed wavefront driver, row scoreboard,
// table-driven back-to-back sequence and hand-written corner cases.
module tb_systolic_psum_collector;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int RW = N * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_psum_collector_if #(.ARRAY_SIZE(N), .ACCUM_WIDTH(W), .FIFO_DEPTH(D)) bus();

  systolic_psum_collector #(.ARRAY_SIZE(N), .ACCUM_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic vld;
    int   base;
    logic rdy;
    int   expCount;
    logic expStall;
  } stepRec;

  int            checks   = 0;
  int            errors   = 0;
  int            popCount = 0;
  logic [RW-1:0] expq [$];
  logic          histValid [N];
  logic [RW-1:0] histRow [N];
  stepRec        b2b [12];

  function automatic logic [RW-1:0] makeRow(input int base);
    logic [RW-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = W'(base + j);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [RW-1:0] actual, input logic [RW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Column j of the vector issued j cycles ago is on the bus; unused slots carry junk
  task automatic applyStimulus(input logic vld, input logic [RW-1:0] row, input logic rdy, input logic push);
    for (int k = N - 1; k > 0; k--) begin
      histValid[k] = histValid[k-1];
      histRow[k]   = histRow[k-1];
    end
    histValid[0] = vld;
    histRow[0]   = row;
    for (int j = 0; j < N; j++) begin
      bus.psum_in[j*W +: W] = histValid[j] ? histRow[j][j*W +: W] : 32'hDEADBEEF;
    end
    bus.psum_in_valid = vld;
    bus.out_ready     = rdy;
    if (push) expq.push_back(row);
    #1;
  endtask

  task automatic advance();
    if (bus.out_valid && bus.out_ready) begin
      popCount++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pop: got %0h expected no row", bus.out_data);
      end else begin
        checkOutput("scoreboard_row", bus.out_data, expq.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    for (int i = 0; i < N + 1; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      advance();
    end
    rst = 1'b0;
    expq.delete();
  endtask

  task automatic drainAll(input int budget);
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      if (expq.size() == 0 && !bus.out_valid) break;
      advance();
    end
    checkOutput("drain_queue_empty", RW'(expq.size()), '0);
    checkOutput("drain_out_valid", bus.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnts [12] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 6, 6};
    int issued;
    int cycles;
    int popStart;
    logic vld;
    logic [RW-1:0] row;

    for (int i = 0; i < 12; i++) begin
      b2b[i].vld      = (i < 6);
      b2b[i].base     = 10 * i;
      b2b[i].rdy      = 1'b0;
      b2b[i].expCount = cnts[i];
      b2b[i].expStall = (cnts[i] >= 4);
    end
    for (int k = 0; k < N; k++) begin
      histValid[k] = 1'b0;
      histRow[k]   = '0;
    end
    bus.psum_in       = '0;
    bus.psum_in_valid = 1'b0;
    bus.out_ready     = 1'b0;

    $display("[TB] reset state");
    resetDut();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("reset_out_valid", bus.out_valid, 1'b0);
    checkOutput("reset_out_data", bus.out_data, '0);
    checkOutput("reset_fifo_count", RW'(bus.fifo_count), '0);
    checkOutput("reset_stall_req", bus.stall_req, 1'b0);
    checkOutput("reset_overflow", bus.overflow, 1'b0);
    advance();

    $display("[TB] single vector");
    resetDut();
    applyStimulus(1'b1, makeRow(100), 1'b0, 1'b1);
    checkOutput("single_valid_c0", bus.out_valid, 1'b0);
    advance();
    for (int c = 1; c < 4; c++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("single_valid_early", bus.out_valid, 1'b0);
      advance();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("single_valid_c4", bus.out_valid, 1'b1);
    checkOutput("single_count_c4", RW'(bus.fifo_count), RW'(1));
    checkOutput("single_data_c4", bus.out_data, makeRow(100));
    advance();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    advance();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("single_valid_after_pop", bus.out_valid, 1'b0);
    checkOutput("single_data_after_pop", bus.out_data, '0);
    advance();

    $display("[TB] back-to-back vectors");
    resetDut();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(b2b[i].vld, makeRow(b2b[i].base), b2b[i].rdy, b2b[i].vld);
      checkOutput("b2b_count", RW'(bus.fifo_count), RW'(b2b[i].expCount));
      checkOutput("b2b_stall", bus.stall_req, b2b[i].expStall);
      checkOutput("b2b_valid", bus.out_valid, b2b[i].expCount != 0);
      advance();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("b2b_overflow", bus.overflow, 1'b0);
    drainAll(30);

    $display("[TB] overflow");
    resetDut();
    for (int c = 0; c < 13; c++) begin
      applyStimulus(c < 9, makeRow(1000 + 10 * c), 1'b0, c < 8);
      if (c == 11) begin
        checkOutput("ovf_count_c11", RW'(bus.fifo_count), RW'(8));
        checkOutput("ovf_flag_c11", bus.overflow, 1'b0);
      end
      if (c == 12) begin
        checkOutput("ovf_count_c12", RW'(bus.fifo_count), RW'(8));
        checkOutput("ovf_flag_c12", bus.overflow, 1'b1);
        checkOutput("ovf_stall_c12", bus.stall_req, 1'b1);
      end
      advance();
    end
    drainAll(30);
    checkOutput("ovf_flag_sticky", bus.overflow, 1'b1);

    $display("[TB] full with simultaneous read and write");
    resetDut();
    for (int c = 0; c < 13; c++) begin
      applyStimulus(c < 9, makeRow(2000 + 10 * c), c == 11, c < 9);
      if (c == 11) checkOutput("fullrw_count_c11", RW'(bus.fifo_count), RW'(8));
      if (c == 12) begin
        checkOutput("fullrw_count_c12", RW'(bus.fifo_count), RW'(8));
        checkOutput("fullrw_overflow", bus.overflow, 1'b0);
      end
      advance();
    end
    drainAll(30);

    $display("[TB] reset mid-stream");
    resetDut();
    applyStimulus(1'b1, makeRow(3000), 1'b0, 1'b0);
    advance();
    applyStimulus(1'b1, makeRow(3010), 1'b0, 1'b0);
    advance();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    advance();
    rst = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
      advance();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("midrst_count", RW'(bus.fifo_count), '0);
    checkOutput("midrst_overflow", bus.overflow, 1'b0);
    checkOutput("midrst_stall", bus.stall_req, 1'b0);
    advance();

    $display("[TB] random streaming");
    resetDut();
    issued   = 0;
    cycles   = 0;
    popStart = popCount;
    while ((issued < 50 || expq.size() != 0 || bus.out_valid) && cycles < 3000) begin
      vld = (issued < 50) && !bus.stall_req && ($urandom_range(0, 1) == 1);
      for (int j = 0; j < N; j++) row[j*W +: W] = $urandom;
      if (vld) issued++;
      applyStimulus(vld, row, $urandom_range(0, 1) == 1, vld);
      advance();
      cycles++;
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("stream_completed", cycles < 3000, 1'b1);
    checkOutput("stream_rows_received", RW'(popCount - popStart), RW'(50));
    checkOutput("stream_queue_empty", RW'(expq.size()), '0);
    checkOutput("stream_overflow", bus.overflow, 1'b0);
    advance();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
